// File: rtl/ahb5_sram_slave_if.sv
// ahb5_sram_slave_if: AHB5 bus bundle between a master/decoder and the SRAM slave.
// Exclusive-access signals exist only when AHB5_SRAM_EXCL_EN is defined.
interface ahb5_sram_slave_if #(
    parameter int DATA_W = 32
);
    logic              hsel;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic              hready_in;
    logic              hnonsec;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hreadyout;
    logic              hresp;
`ifdef AHB5_SRAM_EXCL_EN
    logic              hexcl;
    logic [3:0]        hmaster;
    logic              hexokay;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hready_in, hnonsec, hwdata, hexcl, hmaster,
        input  hrdata, hreadyout, hresp, hexokay
    );
    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hready_in, hnonsec, hwdata, hexcl, hmaster,
        output hrdata, hreadyout, hresp, hexokay
    );
`else
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hready_in, hnonsec, hwdata,
        input  hrdata, hreadyout, hresp
    );
    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hready_in, hnonsec, hwdata,
        output hrdata, hreadyout, hresp
    );
`endif
endinterface

// File: rtl/ahb5_sram_slave.sv
// ahb5_sram_slave: AHB5 register-file RAM with byte lanes, wait states and two-cycle ERROR.
// Define AHB5_SRAM_EXCL_EN to add the one-entry exclusive-access monitor.
module ahb5_sram_slave #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0,
    parameter int SECURE_ONLY = 1
) (
    input logic              hclk,
    input logic              hresetn,
    ahb5_sram_slave_if.slave bus
);
    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t            state, state_n;
    logic              ok, ok_n;
    logic [2:0]        cnt, cnt_n;
    logic [AW-1:0]     a_word;
    logic [OFF-1:0]    a_off;
    logic [2:0]        a_size;
    logic              a_write;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept, err, fin, do_write;
    logic [3:0]        mask;
    logic [NB-1:0]     strb;
    logic              unused_bits;

    assign unused_bits = ^{bus.hburst, bus.htrans[0]};

    always_comb begin
        mask = (4'd1 << bus.hsize[1:0]) - 4'd1;
        err  = (SECURE_ONLY != 0 && bus.hnonsec)
            || ({1'b0, bus.haddr} >= 33'(DEPTH * NB))
            || ((32'd8 << bus.hsize) > 32'(DATA_W))
            || ((bus.haddr[2:0] & mask[2:0]) != 3'd0);
    end

    // New address phases are only taken in a cycle that completes the previous transfer
    assign accept = bus.hsel && bus.hready_in && bus.htrans[1] && (state == IDLE || state == ERR2);
    assign fin    = (state == IDLE) && ok;

    always_comb begin
        state_n = state;
        ok_n    = ok;
        cnt_n   = cnt;
        if (state == WAIT) begin
            cnt_n = cnt + 3'd1;
            if (cnt == 3'(WAIT_STATES - 1))
                state_n = IDLE;
        end else if (state == ERR1) begin
            state_n = ERR2;
        end else if (accept) begin
            state_n = err ? ERR1 : (WAIT_STATES > 0 ? WAIT : IDLE);
            ok_n    = !err;
            cnt_n   = '0;
        end else begin
            state_n = IDLE;
            ok_n    = 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state   <= IDLE;
            ok      <= 1'b0;
            cnt     <= '0;
            a_word  <= '0;
            a_off   <= '0;
            a_size  <= '0;
            a_write <= 1'b0;
        end else begin
            state <= state_n;
            ok    <= ok_n;
            cnt   <= cnt_n;
            if (accept) begin
                a_word  <= bus.haddr[OFF +: AW];
                a_off   <= bus.haddr[OFF-1:0];
                a_size  <= bus.hsize;
                a_write <= bus.hwrite;
            end
        end
    end

    assign bus.hreadyout = !(state == WAIT || state == ERR1);
    assign bus.hresp     = (state == ERR1 || state == ERR2);
    assign bus.hrdata    = (fin && !a_write) ? mem[a_word] : '0;

    always_comb begin
        strb = '0;
        for (int i = 0; i < NB; i++)
            strb[i] = (i >= int'(a_off)) && (i < int'(a_off) + (1 << a_size));
    end

`ifdef AHB5_SRAM_EXCL_EN
    logic          a_excl, mon_v, hit;
    logic [3:0]    a_master, mon_m;
    logic [AW-1:0] mon_w;

    assign hit         = mon_v && (mon_m == a_master) && (mon_w == a_word);
    assign do_write    = fin && a_write && (!a_excl || hit);
    assign bus.hexokay = fin && a_excl && (!a_write || hit);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            a_excl   <= 1'b0;
            a_master <= '0;
            mon_v    <= 1'b0;
            mon_m    <= '0;
            mon_w    <= '0;
        end else begin
            if (accept) begin
                a_excl   <= bus.hexcl;
                a_master <= bus.hmaster;
            end
            // Any committed write to the tracked word, exclusive hit included, drops the reservation
            if (fin && a_excl && !a_write) begin
                mon_v <= 1'b1;
                mon_m <= a_master;
                mon_w <= a_word;
            end else if (do_write && mon_w == a_word) begin
                mon_v <= 1'b0;
            end
        end
    end
`else
    assign do_write = fin && a_write;
`endif

    always_ff @(posedge hclk) begin
        if (do_write)
            for (int i = 0; i < NB; i++)
                if (strb[i])
                    mem[a_word][8*i +: 8] <= bus.hwdata[8*i +: 8];
    end
endmodule
